// File: rtl/regfile_32x64.sv
// 32 x DATA_W register file: two combinational read ports, one synchronous write port.
// Entry ZERO_REG is hardwired to zero. Define REGFILE_BYPASS_EN for same-cycle write-through forwarding.

module regfile_32x64_row #(
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = d_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) data_q <= '0;
    else          data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

module regfile_32x64 #(
  parameter int DATA_W   = 64,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int          NREGS    = 32;
  localparam logic [4:0]  ZERO_IDX = 5'(ZERO_REG);

  logic [NREGS-1:0]             we_dec;
  logic [NREGS-1:0][DATA_W-1:0] rf;

  // Reset gates the decoder so no enable can fire while storage is held clear.
  always_comb begin
    we_dec = '0;
    if (RegWrite && reset_n) we_dec[WriteRegister] = 1'b1;
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    if (g == ZERO_REG) begin : g_zero
      logic zero_en_unused;
      assign zero_en_unused = we_dec[g];
      assign rf[g]          = '0;
    end else begin : g_store
      regfile_32x64_row #(.DATA_W(DATA_W)) u_row (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .en_i    (we_dec[g]),
        .d_i     (WriteData),
        .q_o     (rf[g])
      );
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_ok, byp1, byp2;
  assign byp_ok    = RegWrite && reset_n && (WriteRegister != ZERO_IDX);
  assign byp1      = byp_ok && (WriteRegister == ReadRegister1);
  assign byp2      = byp_ok && (WriteRegister == ReadRegister2);
  assign ReadData1 = byp1 ? WriteData : rf[ReadRegister1];
  assign ReadData2 = byp2 ? WriteData : rf[ReadRegister2];
`else
  assign ReadData1 = rf[ReadRegister1];
  assign ReadData2 = rf[ReadRegister2];
`endif

endmodule

// File: tb/tb_regfile_32x64.sv
// Scoreboard bench for regfile_32x64: stimulus queues expected read data, a negedge monitor compares.

module tb_regfile_32x64;

  localparam int DW = 64;
  localparam logic [DW-1:0] BASE = 64'h0123_4567_89AB_0000;
  localparam logic [DW-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          RegWrite;
  logic [4:0]    WriteRegister;
  logic [DW-1:0] WriteData;
  logic [4:0]    ReadRegister1, ReadRegister2;
  logic [DW-1:0] ReadData1, ReadData2;

  regfile_32x64 #(.DATA_W(DW), .ZERO_REG(31)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } exp_t;

  exp_t exp_q[$];
  logic chk_vld = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  // Monitor: one expectation consumed per flagged cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_vld) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL no_expectation rd1=%h rd2=%h", ReadData1, ReadData2);
        end else begin
          e = exp_q.pop_front();
          checks += 2;
          if (ReadData1 !== e.e1) begin
            errors++;
            $display("FAIL %s port1 idx=%0d got=%h exp=%h", e.name, ReadRegister1, ReadData1, e.e1);
          end
          if (ReadData2 !== e.e2) begin
            errors++;
            $display("FAIL %s port2 idx=%0d got=%h exp=%h", e.name, ReadRegister2, ReadData2, e.e2);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    exp_t e;
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    e.name = name; e.e1 = e1; e.e2 = e2;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    @(posedge clk); #1;
    chk_vld = 1'b0;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [DW-1:0] d);
    RegWrite      = 1'b1;
    WriteRegister = idx;
    WriteData     = d;
    @(posedge clk); #1;
    RegWrite      = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_same;
    int            wait_cyc;
    reset_n = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    repeat (2) @(posedge clk); #1;
    chk("reset_init", 5'd0, 5'd17, '0, '0);
    reset_n = 1'b1;
    chk("post_release", 5'd2, 5'd30, '0, '0);

    // Preload all ones, then clear asynchronously mid-cycle.
    for (int i = 0; i < 32; i++) wr(5'(i), ONES);
    chk("preload", 5'd0, 5'd30, ONES, ONES);
    reset_n = 1'b0;
    for (int i = 0; i < 32; i++) chk("rst_during", 5'(i), 5'(31 - i), '0, '0);
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) chk("rst_after", 5'(i), 5'(31 - i), '0, '0);

    for (int i = 0; i < 31; i++) wr(5'(i), BASE + DW'(i));
    for (int i = 0; i < 31; i++) chk("sweep", 5'(i), 5'(30 - i), BASE + DW'(i), BASE + DW'(30 - i));
    chk("x31", 5'd31, 5'd31, '0, '0);

    wr(5'd31, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("zero_reg", 5'd31, 5'd31, '0, '0);
    for (int i = 0; i < 31; i++) chk("zr_keep", 5'(i), 5'(30 - i), BASE + DW'(i), BASE + DW'(30 - i));

    RegWrite = 1'b0; WriteRegister = 5'd5; WriteData = 64'h5555;
    @(posedge clk); #1;
    chk("wr_disable", 5'd5, 5'd5, BASE + 64'd5, BASE + 64'd5);

    wr(5'd7, 64'h7);
    wr(5'd7, 64'h70);
    chk("b2b_prep", 5'd7, 5'd8, 64'h70, BASE + 64'd8);
    wr(5'd7, 64'h7);
`ifdef REGFILE_BYPASS_EN
    exp_same = 64'h77;
`else
    exp_same = 64'h7;
`endif
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h77;
    chk("same_cyc_pre", 5'd7, 5'd8, exp_same, BASE + 64'd8);
    RegWrite = 1'b0;
    chk("same_cyc_post", 5'd7, 5'd8, 64'h77, BASE + 64'd8);

    // Zero-register write never forwards, even with the bypass built in.
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'h1111;
    chk("zr_no_fwd", 5'd31, 5'd6, '0, BASE + 64'd6);
    RegWrite = 1'b0;

    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'hAAAA;
    #2 reset_n = 1'b0;
    chk("rst_mid_during", 5'd3, 5'd4, '0, '0);
    RegWrite = 1'b0;
    chk("rst_mid_edge", 5'd3, 5'd3, '0, '0);
    reset_n = 1'b1;
    chk("rst_mid_rel", 5'd3, 5'd4, '0, '0);
    wr(5'd3, 64'h1234);
    chk("post_rst_wr", 5'd3, 5'd31, 64'h1234, '0);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
